mp5_phantom_map: RTL

MP5_PHANTOM_MAP -- requirements
Module: mp5_phantom_map

---
 rtl/mp5_phantom_map.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mp5_phantom_map.sv
// mp5_phantom_map: associative map from phantom packet id to the FIFO slot
// holding that phantom. Records come from the downstream stage; arriving
// real packets that hit the map become insert commands, everything else is
// forwarded as a push.
// Optional feature macro: MP5_MAP_AGING_EN (entry aging with AGE_LIMIT).
//
// Handshake: there is no back-pressure. rec_valid and pkt_valid are accepted
// on every posedge where rst is low. ins_valid / push_valid are one-cycle
// pulses issued on the cycle after the packet that caused them, and at most
// one of them is high in any cycle.

package mp5_phantom_map_pkg;
    // 560-bit packet: id, phantom flag, target pipeline, opaque payload.
    typedef struct packed {
        logic [15:0]  id;
        logic         is_phantom;
        logic [7:0]   pipeline;
        logic [534:0] payload;
    } Packet;
endpackage

module mp5_phantom_map
    import mp5_phantom_map_pkg::*;
#(
    parameter int NUM_PIPELINES = 8,
    parameter int FIFO_SIZE     = 8,
    parameter int MAP_DEPTH     = 16,
    parameter int AGE_LIMIT     = 1024,
    localparam int FID_W = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1,
    localparam int AW    = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1,
    localparam int IDX_W = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1,
    localparam int OCC_W = $clog2(MAP_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_valid,
    input  logic [15:0]      rec_id,
    input  logic [FID_W-1:0] rec_fifo_id,
    input  logic [AW-1:0]    rec_addr,
    input  logic             pkt_valid,
    input  Packet            pkt_in,
    output logic             ins_valid,
    output logic [FID_W-1:0] ins_fifo_id,
    output logic [AW-1:0]    ins_addr,
    output logic             push_valid,
    output logic [FID_W-1:0] fifo_id_out,
    output Packet            pkt_out,
    output logic [OCC_W-1:0] occupancy,
    output logic             overflow
);

    // Table storage.
    logic [MAP_DEPTH-1:0] r_valid;
    logic [15:0]          r_id   [MAP_DEPTH];
    logic [FID_W-1:0]     r_fid  [MAP_DEPTH];
    logic [AW-1:0]        r_addr [MAP_DEPTH];

`ifdef MP5_MAP_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_LIMIT - 1);
    logic [AGE_W-1:0]     r_age  [MAP_DEPTH];
    logic [MAP_DEPTH-1:0] w_expire;
`endif

    logic                 w_lookup;
    logic                 w_bypass;
    logic [MAP_DEPTH-1:0] w_rec_match;
    logic [MAP_DEPTH-1:0] w_pkt_match;
    logic                 w_pkt_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    logic [IDX_W-1:0]     w_rec_idx;
    logic                 w_free_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_wr_en;
    logic [IDX_W-1:0]     w_wr_idx;
    logic                 w_drop;
    logic [MAP_DEPTH-1:0] w_valid_nxt;
    logic [OCC_W-1:0]     w_occ_nxt;
    logic                 w_ins;
    logic [FID_W-1:0]     w_ins_fid;
    logic [AW-1:0]        w_ins_addr;

    assign w_lookup  = pkt_valid && !pkt_in.is_phantom;
    // A record and a lookup on the same id resolve directly from the record.
    assign w_bypass  = rec_valid && w_lookup && (rec_id == pkt_in.id);
    assign w_pkt_hit = w_lookup && (|w_pkt_match);
    assign w_ins     = w_bypass || w_pkt_hit;
    assign w_ins_fid  = w_bypass ? rec_fifo_id : r_fid[w_hit_idx];
    assign w_ins_addr = w_bypass ? rec_addr    : r_addr[w_hit_idx];

`ifdef MP5_MAP_AGING_EN
    // Entries whose age would reach AGE_LIMIT on this edge expire.
    always_comb begin
        w_expire = '0;
        for (int i = 0; i < MAP_DEPTH; i++) begin
            w_expire[i] = r_valid[i] && (r_age[i] >= AGE_LAST);
        end
    end
`endif

    // Associative compare of the record id and the lookup id, lowest-index encode.
    always_comb begin
        w_rec_match  = '0;
        w_pkt_match  = '0;
        w_hit_idx    = '0;
        w_rec_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = MAP_DEPTH - 1; i >= 0; i--) begin
            w_rec_match[i] = r_valid[i] && (r_id[i] == rec_id);
            w_pkt_match[i] = r_valid[i] && (r_id[i] == pkt_in.id);
            if (w_rec_match[i]) w_rec_idx = IDX_W'(i);
            if (w_pkt_match[i]) w_hit_idx = IDX_W'(i);
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Record placement: overwrite a matching entry, else lowest free, else drop.
    // Entries freed by this cycle's hit are still valid here, so never reused.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        w_drop   = 1'b0;
        if (rec_valid && !w_bypass) begin
            if (|w_rec_match) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_rec_idx;
            end else if (w_free_found) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_free_idx;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // Next valid vector and its population count (becomes occupancy).
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_lookup) w_valid_nxt = w_valid_nxt & ~w_pkt_match;
`ifdef MP5_MAP_AGING_EN
        w_valid_nxt = w_valid_nxt & ~w_expire;
`endif
        if (w_wr_en) w_valid_nxt[w_wr_idx] = 1'b1;
        w_occ_nxt = '0;
        for (int i = 0; i < MAP_DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    // Table state, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < MAP_DEPTH; i++) begin
                r_id[i]   <= '0;
                r_fid[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_valid   <= w_valid_nxt;
            occupancy <= w_occ_nxt;
            if (w_drop) overflow <= 1'b1;
            if (w_wr_en) begin
                r_id[w_wr_idx]   <= rec_id;
                r_fid[w_wr_idx]  <= rec_fifo_id;
                r_addr[w_wr_idx] <= rec_addr;
            end
        end
    end

`ifdef MP5_MAP_AGING_EN
    // Per-entry age: cleared on write, counts while valid, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAP_DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < MAP_DEPTH; i++) begin
                if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
                    r_age[i] <= '0;
                end else if (r_valid[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end
`endif

    // Command outputs: one pulse per packet, data fields hold between commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_valid   <= 1'b0;
            push_valid  <= 1'b0;
            ins_fifo_id <= '0;
            ins_addr    <= '0;
            fifo_id_out <= '0;
            pkt_out     <= '0;
        end else begin
            ins_valid  <= 1'b0;
            push_valid <= 1'b0;
            if (w_ins) begin
                ins_valid   <= 1'b1;
                ins_fifo_id <= w_ins_fid;
                ins_addr    <= w_ins_addr;
                fifo_id_out <= w_ins_fid;
                pkt_out     <= pkt_in;
            end else if (pkt_valid) begin
                push_valid  <= 1'b1;
                fifo_id_out <= pkt_in.pipeline[FID_W-1:0];
                pkt_out     <= pkt_in;
            end
        end
    end

endmodule
